mem_port_arbiter: RTL and testbench

Shares one downstream memory port between the core's instruction-fetch requester and its data-load/store requester. Arbitrates request handshakes and holds a granted request stable until the memory accepts it. Records the source of every accepted request in an in-order tag FIFO, and routes each in-order memory response back to the requester that issued it. Sits between the core's fetch/data interfaces and a single-ported unified memory or bus bridge.

---
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream memory port between the instruction-fetch (imem) and
// data load/store (dmem) requesters. Grants are held stable until the memory accepts them. An
// in-order tag FIFO records the source of each accepted request so that in-order responses can be
// routed back to the requester that issued them.
// Optional feature: define MEM_PORT_ARBITER_RR_EN for round-robin arbitration. When it is not
// defined, dmem has fixed priority over imem.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    imem_req_valid,
  output logic                    imem_req_ready,
  input  logic [ADDR_WIDTH-1:0]   imem_req_addr,
  output logic                    imem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   imem_rsp_rdata,
  input  logic                    dmem_req_valid,
  output logic                    dmem_req_ready,
  input  logic [ADDR_WIDTH-1:0]   dmem_req_addr,
  input  logic                    dmem_req_write,
  input  logic [DATA_WIDTH/8-1:0] dmem_req_wstrb,
  input  logic [DATA_WIDTH-1:0]   dmem_req_wdata,
  output logic                    dmem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   dmem_rsp_rdata,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_write,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata,
  output logic                    err_unexpected_rsp
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned PtrW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW  = $clog2(MAX_OUTSTANDING + 1);

  // Source IDs: 0 = imem, 1 = dmem.
  localparam logic SrcImem = 1'b0;
  localparam logic SrcDmem = 1'b1;

  logic [MAX_OUTSTANDING-1:0] tag_q;
  logic [PtrW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]            cnt_q;
  logic                       lock_q, lock_src_q;
  logic                       err_q;

  logic sel;
  logic sel_valid;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head;

`ifdef MEM_PORT_ARBITER_RR_EN
  logic last_q;
`endif

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CntW'(MAX_OUTSTANDING));
  assign empty = (cnt_q == '0);

  // Pick the source: the locked one if a grant is pending, otherwise by priority policy.
  always_comb begin
    sel = SrcImem;
    if (lock_q) begin
      sel = lock_src_q;
    end else begin
`ifdef MEM_PORT_ARBITER_RR_EN
      if (imem_req_valid && dmem_req_valid) begin
        sel = ~last_q;
      end else begin
        sel = dmem_req_valid;
      end
`else
      sel = dmem_req_valid;
`endif
    end
  end

  // Request-side handshake and payload mux; everything is held at zero during reset.
  always_comb begin
    sel_valid      = sel ? dmem_req_valid : imem_req_valid;
    // mem_req_valid must not depend on mem_req_ready.
    mem_req_valid  = rst_n && sel_valid && !full;
    imem_req_ready = rst_n && mem_req_ready && !full && (sel == SrcImem);
    dmem_req_ready = rst_n && mem_req_ready && !full && (sel == SrcDmem);
    push           = mem_req_valid && mem_req_ready;
    mem_addr       = '0;
    mem_write      = 1'b0;
    mem_wstrb      = '0;
    mem_wdata      = '0;
    if (rst_n) begin
      if (sel == SrcDmem) begin
        mem_addr  = dmem_req_addr;
        mem_write = dmem_req_write;
        mem_wstrb = dmem_req_wstrb;
        mem_wdata = dmem_req_wdata;
      end else begin
        mem_addr  = imem_req_addr;
      end
    end
  end

  // Response routing: pop the oldest tag and steer the response to its owner.
  always_comb begin
    head           = tag_q[rd_ptr_q];
    pop            = rst_n && mem_rsp_valid && !empty;
    imem_rsp_valid = pop && (head == SrcImem);
    dmem_rsp_valid = pop && (head == SrcDmem);
    imem_rsp_rdata = mem_rsp_rdata;
    dmem_rsp_rdata = mem_rsp_rdata;
  end

  assign err_unexpected_rsp = err_q;

  // Tag FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= sel;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Grant lock: a stalled request keeps its source until the memory accepts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      lock_src_q <= SrcImem;
    end else if (push) begin
      lock_q     <= 1'b0;
    end else if (mem_req_valid) begin
      lock_q     <= 1'b1;
      lock_src_q <= sel;
    end
  end

  // Sticky flag for a response with no outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (mem_rsp_valid && empty) begin
      err_q <= 1'b1;
    end
  end

`ifdef MEM_PORT_ARBITER_RR_EN
  // Last-granted source; resets to imem so dmem wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= SrcImem;
    end else if (push) begin
      last_q <= sel;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Inputs change on the falling edge and outputs are
// sampled 1ns later; expected responses are queued when a grant is expected and checked when the
// bench's memory model returns them.
module tb_mem_port_arbiter;

`ifdef MEM_PORT_ARBITER_RR_EN
  localparam bit RrMode = 1'b1;
`else
  localparam bit RrMode = 1'b0;
`endif

  typedef struct packed {
    logic        src;
    logic [31:0] data;
  } exp_t;

  logic        clk, rst_n;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_rdata;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_write, dmem_rsp_valid;
  logic [31:0] dmem_req_addr, dmem_req_wdata, dmem_rsp_rdata;
  logic [3:0]  dmem_req_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_write, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rsp_rdata;
  logic [3:0]  mem_wstrb;
  logic        err_unexpected_rsp;

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb[$];

  mem_port_arbiter dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .imem_req_valid     (imem_req_valid),
    .imem_req_ready     (imem_req_ready),
    .imem_req_addr      (imem_req_addr),
    .imem_rsp_valid     (imem_rsp_valid),
    .imem_rsp_rdata     (imem_rsp_rdata),
    .dmem_req_valid     (dmem_req_valid),
    .dmem_req_ready     (dmem_req_ready),
    .dmem_req_addr      (dmem_req_addr),
    .dmem_req_write     (dmem_req_write),
    .dmem_req_wstrb     (dmem_req_wstrb),
    .dmem_req_wdata     (dmem_req_wdata),
    .dmem_rsp_valid     (dmem_rsp_valid),
    .dmem_rsp_rdata     (dmem_rsp_rdata),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_addr           (mem_addr),
    .mem_write          (mem_write),
    .mem_wstrb          (mem_wstrb),
    .mem_wdata          (mem_wdata),
    .mem_rsp_valid      (mem_rsp_valid),
    .mem_rsp_rdata      (mem_rsp_rdata),
    .err_unexpected_rsp (err_unexpected_rsp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    imem_req_valid = 1'b0;
    imem_req_addr  = '0;
    dmem_req_valid = 1'b0;
    dmem_req_addr  = '0;
    dmem_req_write = 1'b0;
    dmem_req_wstrb = '0;
    dmem_req_wdata = '0;
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_rdata  = '0;
  endtask

  // Memory model: return the oldest expected response.
  task automatic drive_rsp(output exp_t e);
    e = sb.pop_front();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = e.data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_req_valid = 1'b1; imem_req_addr = 32'h11;
    dmem_req_valid = 1'b1; dmem_req_addr = 32'h22; dmem_req_write = 1'b1;
    dmem_req_wstrb = 4'hF; dmem_req_wdata = 32'h33;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h44;
    #1;
    tests_run++;
    if ({mem_req_valid, imem_req_ready, dmem_req_ready, imem_rsp_valid, dmem_rsp_valid}
        !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_valids: got %b required 00000",
               {mem_req_valid, imem_req_ready, dmem_req_ready, imem_rsp_valid, dmem_rsp_valid});
    end
    tests_run++;
    if ({mem_addr, mem_write, mem_wstrb, mem_wdata, err_unexpected_rsp} !== '0) begin
      tests_failed++;
      $display("FAIL reset_payload: addr %h write %b wstrb %h wdata %h err %b required all 0",
               mem_addr, mem_write, mem_wstrb, mem_wdata, err_unexpected_rsp);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_fetch();
    exp_t e;
    imem_req_valid = 1'b1; imem_req_addr = 32'h100; mem_req_ready = 1'b1;
    #1;
    tests_run++;
    if ({mem_req_valid, imem_req_ready, dmem_req_ready, mem_write} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL fetch_handshake: valid/irdy/drdy/write %b required 1100",
               {mem_req_valid, imem_req_ready, dmem_req_ready, mem_write});
    end
    tests_run++;
    if ({mem_addr, mem_wstrb} !== {32'h100, 4'h0}) begin
      tests_failed++;
      $display("FAIL fetch_payload: addr %h wstrb %h required 00000100 0", mem_addr, mem_wstrb);
    end
    sb.push_back(exp_t'({1'b0, 32'hDEADBEEF}));
    @(negedge clk);
    imem_req_valid = 1'b0;
    #1;
    tests_run++;
    if (mem_req_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fetch_idle: mem_req_valid %b required 0", mem_req_valid);
    end
    @(negedge clk);
    drive_rsp(e);
    #1;
    tests_run++;
    if ({imem_rsp_valid, dmem_rsp_valid, imem_rsp_rdata} !== {~e.src, e.src, e.data}) begin
      tests_failed++;
      $display("FAIL fetch_rsp: i/d valid %b%b data %h required %b%b %h",
               imem_rsp_valid, dmem_rsp_valid, imem_rsp_rdata, ~e.src, e.src, e.data);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_contention();
    exp_t e;
    imem_req_valid = 1'b1; imem_req_addr = 32'h104;
    dmem_req_valid = 1'b1; dmem_req_addr = 32'h200; dmem_req_write = 1'b1;
    dmem_req_wstrb = 4'hF; dmem_req_wdata = 32'h55;
    mem_req_ready = 1'b1;
    #1;
    tests_run++;
    if ({imem_req_ready, dmem_req_ready, mem_addr, mem_write, mem_wdata}
        !== {2'b01, 32'h200, 1'b1, 32'h55}) begin
      tests_failed++;
      $display("FAIL contention_first: rdy %b%b addr %h write %b wdata %h required 01 200 1 55",
               imem_req_ready, dmem_req_ready, mem_addr, mem_write, mem_wdata);
    end
    sb.push_back(exp_t'({1'b1, 32'h1}));
    @(negedge clk);
    dmem_req_valid = 1'b0;
    #1;
    tests_run++;
    if ({imem_req_ready, dmem_req_ready, mem_addr, mem_write} !== {2'b10, 32'h104, 1'b0}) begin
      tests_failed++;
      $display("FAIL contention_second: rdy %b%b addr %h write %b required 10 104 0",
               imem_req_ready, dmem_req_ready, mem_addr, mem_write);
    end
    sb.push_back(exp_t'({1'b0, 32'h2}));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      imem_req_valid = 1'b0;
      drive_rsp(e);
      #1;
      tests_run++;
      if ({imem_rsp_valid, dmem_rsp_valid, imem_rsp_rdata, dmem_rsp_rdata}
          !== {~e.src, e.src, e.data, e.data}) begin
        tests_failed++;
        $display("FAIL contention_rsp%0d: i/d valid %b%b data %h required %b%b %h", i,
                 imem_rsp_valid, dmem_rsp_valid, dmem_rsp_rdata, ~e.src, e.src, e.data);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_lock();
    exp_t e;
    imem_req_valid = 1'b1; imem_req_addr = 32'h300; mem_req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        dmem_req_valid = 1'b1; dmem_req_addr = 32'h400; dmem_req_write = 1'b0;
      end
      #1;
      tests_run++;
      if ({mem_req_valid, imem_req_ready, dmem_req_ready, mem_addr} !== {3'b100, 32'h300}) begin
        tests_failed++;
        $display("FAIL lock_hold%0d: v/irdy/drdy %b addr %h required 100 300", c,
                 {mem_req_valid, imem_req_ready, dmem_req_ready}, mem_addr);
      end
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    #1;
    tests_run++;
    if ({mem_req_valid, imem_req_ready, dmem_req_ready, mem_addr} !== {3'b110, 32'h300}) begin
      tests_failed++;
      $display("FAIL lock_release: v/irdy/drdy %b addr %h required 110 300",
               {mem_req_valid, imem_req_ready, dmem_req_ready}, mem_addr);
    end
    sb.push_back(exp_t'({1'b0, 32'h33}));
    @(negedge clk);
    imem_req_valid = 1'b0;
    #1;
    tests_run++;
    if ({mem_req_valid, imem_req_ready, dmem_req_ready, mem_addr} !== {3'b101, 32'h400}) begin
      tests_failed++;
      $display("FAIL lock_next: v/irdy/drdy %b addr %h required 101 400",
               {mem_req_valid, imem_req_ready, dmem_req_ready}, mem_addr);
    end
    sb.push_back(exp_t'({1'b1, 32'h44}));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      dmem_req_valid = 1'b0;
      drive_rsp(e);
      #1;
      tests_run++;
      if ({imem_rsp_valid, dmem_rsp_valid, imem_rsp_rdata} !== {~e.src, e.src, e.data}) begin
        tests_failed++;
        $display("FAIL lock_rsp%0d: i/d valid %b%b data %h required %b%b %h", i,
                 imem_rsp_valid, dmem_rsp_valid, imem_rsp_rdata, ~e.src, e.src, e.data);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_full();
    exp_t e;
    dmem_req_valid = 1'b1; dmem_req_write = 1'b1; dmem_req_wstrb = 4'hF;
    dmem_req_wdata = 32'hA0; mem_req_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dmem_req_addr = 32'h500 + 32'(4 * i);
      #1;
      tests_run++;
      if ({mem_req_valid, dmem_req_ready} !== 2'b11) begin
        tests_failed++;
        $display("FAIL full_fill%0d: valid/drdy %b required 11", i,
                 {mem_req_valid, dmem_req_ready});
      end
      sb.push_back(exp_t'({1'b1, 32'h50 + 32'(i)}));
      @(negedge clk);
    end
    dmem_req_addr = 32'h508;
    #1;
    tests_run++;
    if ({mem_req_valid, dmem_req_ready, imem_req_ready} !== 3'b000) begin
      tests_failed++;
      $display("FAIL full_block: valid/drdy/irdy %b required 000",
               {mem_req_valid, dmem_req_ready, imem_req_ready});
    end
    @(negedge clk);
    drive_rsp(e);
    #1;
    tests_run++;
    if ({mem_req_valid, dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata}
        !== {3'b001, e.data}) begin
      tests_failed++;
      $display("FAIL full_pop_same_cycle: valid/drdy/rspv %b data %h required 001 %h",
               {mem_req_valid, dmem_req_ready, dmem_rsp_valid}, dmem_rsp_rdata, e.data);
    end
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    tests_run++;
    if ({mem_req_valid, dmem_req_ready, mem_addr} !== {2'b11, 32'h508}) begin
      tests_failed++;
      $display("FAIL full_reopen: valid/drdy %b addr %h required 11 508",
               {mem_req_valid, dmem_req_ready}, mem_addr);
    end
    sb.push_back(exp_t'({1'b1, 32'h52}));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      dmem_req_valid = 1'b0;
      drive_rsp(e);
      #1;
      tests_run++;
      if ({imem_rsp_valid, dmem_rsp_valid, dmem_rsp_rdata} !== {~e.src, e.src, e.data}) begin
        tests_failed++;
        $display("FAIL full_drain%0d: i/d valid %b%b data %h required %b%b %h", i,
                 imem_rsp_valid, dmem_rsp_valid, dmem_rsp_rdata, ~e.src, e.src, e.data);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_stray();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hBAD;
    #1;
    tests_run++;
    if ({imem_rsp_valid, dmem_rsp_valid, err_unexpected_rsp} !== 3'b000) begin
      tests_failed++;
      $display("FAIL stray_no_rsp: i/d valid/err %b required 000",
               {imem_rsp_valid, dmem_rsp_valid, err_unexpected_rsp});
    end
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      tests_run++;
      if (err_unexpected_rsp !== 1'b1) begin
        tests_failed++;
        $display("FAIL stray_err_sticky%0d: err %b required 1", c, err_unexpected_rsp);
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (err_unexpected_rsp !== 1'b0) begin
      tests_failed++;
      $display("FAIL stray_err_clear: err %b required 0", err_unexpected_rsp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    imem_req_valid = 1'b1; imem_req_addr = 32'h600; mem_req_ready = 1'b1;
    #1;
    tests_run++;
    if (imem_req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_accept: irdy %b required 1", imem_req_ready);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h77;
    #1;
    tests_run++;
    if ({imem_rsp_valid, dmem_rsp_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL midreset_tag_dropped: i/d valid %b%b required 00",
               imem_rsp_valid, dmem_rsp_valid);
    end
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    tests_run++;
    if (err_unexpected_rsp !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_err: err %b required 1", err_unexpected_rsp);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Both requesters valid every cycle with a response each cycle keeps one slot free.
  task automatic test_back_to_back();
    exp_t e;
    logic src;
    imem_req_addr = 32'h700; dmem_req_addr = 32'h800; dmem_req_write = 1'b0;
    mem_req_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imem_req_valid = (i < 4);
      dmem_req_valid = (i < 4);
      if (i >= 1) drive_rsp(e);
      #1;
      if (i >= 1) begin
        tests_run++;
        if ({imem_rsp_valid, dmem_rsp_valid, imem_rsp_rdata} !== {~e.src, e.src, e.data}) begin
          tests_failed++;
          $display("FAIL b2b_rsp%0d: i/d valid %b%b data %h required %b%b %h", i,
                   imem_rsp_valid, dmem_rsp_valid, imem_rsp_rdata, ~e.src, e.src, e.data);
        end
      end
      if (i < 4) begin
        src = RrMode ? (i % 2 == 0) : 1'b1;
        tests_run++;
        if ({imem_req_ready, dmem_req_ready, mem_addr}
            !== {~src, src, (src ? 32'h800 : 32'h700)}) begin
          tests_failed++;
          $display("FAIL b2b_grant%0d: rdy %b%b addr %h required %b%b", i,
                   imem_req_ready, dmem_req_ready, mem_addr, ~src, src);
        end
        sb.push_back(exp_t'({src, 32'h1000 + 32'(i)}));
      end
      @(negedge clk);
      mem_rsp_valid = 1'b0;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single_fetch();
    test_contention();
    test_lock();
    test_full();
    test_stray();
    test_reset_mid();
    test_back_to_back();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_empty: %0d entries left required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
